serial_line_echo: RTL

- Byte-stream consumer and producer between the AVR serial receive/transmit handshake and the rest of the FPGA design.
- Collects received bytes into a line buffer with backspace editing.
- On a terminator byte, or when the buffer is full, transmits "> " + line + CR LF back through the tx handshake, honouring tx_busy.
- Replaces the fixed-message sender as the serial endpoint of the top level.

---
 rtl/serial_line_echo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/serial_line_echo.sv
// serial_line_echo: collects received bytes into an editable line buffer and
//   echoes "> " + line + CR LF through the transmit handshake on a terminator
//   byte or when the buffer fills.
// Latency: terminator strobe at cycle N -> line_busy and first '>' strobe at N+1
//   when tx_busy is low.
// Backpressure: emits only while tx_busy=0, with a mandatory idle cycle after each
//   strobe; bytes received while flushing are dropped and counted (saturating).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rx_data/new_rx_data  received byte and its one-cycle strobe
//   tx_data/new_tx_data  byte to transmit and its one-cycle strobe
//   tx_busy            transmitter busy (no strobe while high)
//   line_busy          high while a flush is in progress
//   drop_count         saturating count of bytes dropped while flushing
module serial_line_echo #(
  parameter int          DEPTH  = 32,
  parameter int          ADDR_W = 5,
  parameter logic [7:0]  TERM   = 8'h0D,
  parameter logic [7:0]  BKSP   = 8'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  output logic       line_busy,
  output logic [7:0] drop_count
);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_PFX1,
    S_PFX2,
    S_DATA,
    S_CR,
    S_LF
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE     = 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic              gap_q, gap_d;
  logic [7:0]        last_tx_q;
  logic [7:0]        drop_q;
  logic [7:0]        rdata_q;
  logic [7:0]        mem [DEPTH];

  logic              wr_en;
  logic              strobe;
  logic [7:0]        tx_byte;
  state_t            after_state;
  logic [ADDR_W:0]   after_idx;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    gap_d       = gap_q;
    wr_en       = 1'b0;
    strobe      = 1'b0;
    tx_byte     = last_tx_q;
    after_state = state_q;
    after_idx   = rd_idx_q;

    case (state_q)
      S_COLLECT: begin
        gap_d = 1'b0;
        if (new_rx_data) begin
          if (rx_data == TERM) begin
            state_d = S_PFX1;
          end else if (rx_data == BKSP) begin
            if (count_q != '0) begin
              count_d = count_q - ONE;
            end
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + ONE;
            // Full buffer flushes on its own; count never reaches DEPTH in COLLECT.
            if (count_q + ONE == DEPTH_C) begin
              state_d = S_PFX1;
            end
          end
        end
      end
      S_PFX1: begin
        tx_byte     = 8'h3E;
        after_state = S_PFX2;
      end
      S_PFX2: begin
        tx_byte     = 8'h20;
        after_state = (count_q == '0) ? S_CR : S_DATA;
      end
      S_DATA: begin
        // rdata_q always mirrors mem[rd_idx_q], so no extra read bubble here.
        tx_byte = rdata_q;
        if (rd_idx_q + ONE == count_q) begin
          after_state = S_CR;
          after_idx   = '0;
        end else begin
          after_state = S_DATA;
          after_idx   = rd_idx_q + ONE;
        end
      end
      S_CR: begin
        tx_byte     = 8'h0D;
        after_state = S_LF;
      end
      S_LF: begin
        tx_byte     = 8'h0A;
        after_state = S_COLLECT;
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase

    // Emit states: a strobe advances the sequence and forces one idle cycle,
    // since the transmitter only raises busy the cycle after the strobe.
    if (state_q != S_COLLECT) begin
      if (gap_q) begin
        gap_d = 1'b0;
      end else if (!tx_busy && !rst) begin
        strobe   = 1'b1;
        gap_d    = 1'b1;
        state_d  = after_state;
        rd_idx_d = after_idx;
        if (state_q == S_LF) begin
          count_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_COLLECT;
      count_q   <= '0;
      rd_idx_q  <= '0;
      gap_q     <= 1'b0;
      last_tx_q <= 8'h00;
      drop_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      gap_q    <= gap_d;
      if (strobe) begin
        last_tx_q <= tx_byte;
      end
      if (line_busy && new_rx_data && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'h01;
      end
    end
  end

  // Buffer storage has no reset; the read port tracks the next read index so
  // mem[0] is already in rdata_q by the time DATA is entered.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[ADDR_W-1:0]] <= rx_data;
    end
    rdata_q <= mem[rd_idx_d[ADDR_W-1:0]];
  end

  assign new_tx_data = strobe;
  assign tx_data     = strobe ? tx_byte : last_tx_q;
  assign line_busy   = (state_q != S_COLLECT);
  assign drop_count  = drop_q;

endmodule
